uart_alu_if: RTL and testbench

UART_ALU_IF -- requirements
Module: uart_alu_if

---
 rtl/uart_alu_if.sv | 138 +++++++++++++
 tb/tb_uart_alu_if.sv | 307 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_alu_if.sv
// uart_alu_if
// Bridges a byte-oriented UART to a small ALU. Three received bytes form one
// request: operand A, operand B, then an opcode byte whose low NB_OP bits
// select the operation. The result is handed to the transmitter as a single
// byte. No new request is accepted until the transmitter reports completion.
//
// Parameters:
//   NB_DATA    - data byte / operand width
//   NB_OP      - opcode width taken from the low bits of the opcode byte
// Ports:
//   i_clk      - clock, all state changes on the rising edge
//   i_rst_n    - asynchronous active-low reset
//   i_rx_data  - received byte, valid while i_rx_done is high
//   i_rx_done  - receiver strobe, sampled as a level every cycle
//   i_tx_done  - transmitter end-of-byte strobe
//   o_tx_data  - result byte, held stable until the transmitter finishes
//   o_tx_start - one-cycle request to transmit o_tx_data
//   o_op_err   - one-cycle flag, coincident with o_tx_start, for a bad opcode
//   o_overrun  - one-cycle flag for a byte dropped while a result is in flight
module uart_alu_if #(
    parameter int NB_DATA = 8,
    parameter int NB_OP   = 6
) (
    input  logic               i_clk,
    input  logic               i_rst_n,
    input  logic [NB_DATA-1:0] i_rx_data,
    input  logic               i_rx_done,
    input  logic               i_tx_done,
    output logic [NB_DATA-1:0] o_tx_data,
    output logic               o_tx_start,
    output logic               o_op_err,
    output logic               o_overrun
);

    typedef enum logic [2:0] {
        WAIT_A,
        WAIT_B,
        WAIT_OP,
        SEND,
        WAIT_TX
    } state_t;

    localparam logic [NB_OP-1:0] OP_ADD = NB_OP'(6'b100000);
    localparam logic [NB_OP-1:0] OP_SUB = NB_OP'(6'b100010);
    localparam logic [NB_OP-1:0] OP_AND = NB_OP'(6'b100100);
    localparam logic [NB_OP-1:0] OP_OR  = NB_OP'(6'b100101);
    localparam logic [NB_OP-1:0] OP_XOR = NB_OP'(6'b100110);
    localparam logic [NB_OP-1:0] OP_NOR = NB_OP'(6'b100111);
    localparam logic [NB_OP-1:0] OP_SRL = NB_OP'(6'b000010);
    localparam logic [NB_OP-1:0] OP_SRA = NB_OP'(6'b000011);

    // Shift amounts at or beyond the operand width saturate explicitly, so
    // the result never depends on how a tool treats oversized shifts.
    localparam logic [NB_DATA-1:0] SHIFT_LIMIT = NB_DATA'(NB_DATA);

    state_t             state;
    logic [NB_DATA-1:0] op_a;
    logic [NB_DATA-1:0] op_b;
    logic [NB_OP-1:0]   opcode;
    logic [NB_DATA-1:0] alu_result;
    logic               alu_valid;

    // ALU result from the captured operands. It is only consumed in SEND,
    // when all three registers are settled.
    always_comb begin
        alu_result = '0;
        alu_valid  = 1'b1;
        case (opcode)
            OP_ADD: alu_result = op_a + op_b;
            OP_SUB: alu_result = op_a - op_b;
            OP_AND: alu_result = op_a & op_b;
            OP_OR:  alu_result = op_a | op_b;
            OP_XOR: alu_result = op_a ^ op_b;
            OP_NOR: alu_result = ~(op_a | op_b);
            OP_SRL: alu_result = (op_b >= SHIFT_LIMIT) ? '0 : (op_a >> op_b);
            OP_SRA: alu_result = (op_b >= SHIFT_LIMIT) ? {NB_DATA{op_a[NB_DATA-1]}}
                                                       : $unsigned($signed(op_a) >>> op_b);
            default: alu_valid = 1'b0;
        endcase
    end

    // Request sequencer with registered outputs. Pulse outputs default low
    // every cycle so each one lasts exactly one clock. A byte arriving in
    // SEND or WAIT_TX is dropped and only raises o_overrun; the state and
    // operands are left alone, and i_tx_done still takes effect on the
    // same edge.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state      <= WAIT_A;
            op_a       <= '0;
            op_b       <= '0;
            opcode     <= '0;
            o_tx_data  <= '0;
            o_tx_start <= 1'b0;
            o_op_err   <= 1'b0;
            o_overrun  <= 1'b0;
        end else begin
            o_tx_start <= 1'b0;
            o_op_err   <= 1'b0;
            o_overrun  <= 1'b0;
            case (state)
                WAIT_A: begin
                    if (i_rx_done) begin
                        op_a  <= i_rx_data;
                        state <= WAIT_B;
                    end
                end
                WAIT_B: begin
                    if (i_rx_done) begin
                        op_b  <= i_rx_data;
                        state <= WAIT_OP;
                    end
                end
                WAIT_OP: begin
                    if (i_rx_done) begin
                        opcode <= i_rx_data[NB_OP-1:0];
                        state  <= SEND;
                    end
                end
                SEND: begin
                    o_tx_data  <= alu_result;
                    o_tx_start <= 1'b1;
                    o_op_err   <= ~alu_valid;
                    o_overrun  <= i_rx_done;
                    state      <= WAIT_TX;
                end
                WAIT_TX: begin
                    o_overrun <= i_rx_done;
                    if (i_tx_done) begin
                        state <= WAIT_A;
                    end
                end
                default: state <= WAIT_A;
            endcase
        end
    end

endmodule

// File: tb/tb_uart_alu_if.sv
// tb_uart_alu_if
// Self-checking bench for uart_alu_if: a table of directed requests, hand
// sequences for overrun, held receiver strobes and reset, then randomized
// requests checked against an arithmetic reference model.
module tb_uart_alu_if;

    localparam int NB_DATA  = 8;
    localparam int NB_OP    = 6;
    localparam int NUM_VECS = 16;
    localparam int NUM_RAND = 40;

    logic               i_clk     = 1'b0;
    logic               i_rst_n   = 1'b0;
    logic [NB_DATA-1:0] i_rx_data = '0;
    logic               i_rx_done = 1'b0;
    logic               i_tx_done = 1'b0;
    logic [NB_DATA-1:0] o_tx_data;
    logic               o_tx_start;
    logic               o_op_err;
    logic               o_overrun;

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic [7:0] a;
        logic [7:0] b;
        logic [7:0] op_byte;
        logic [7:0] exp_data;
        logic       exp_err;
    } vec_t;

    vec_t vecs [NUM_VECS];

    always #5 i_clk = ~i_clk;

    uart_alu_if #(
        .NB_DATA(NB_DATA),
        .NB_OP  (NB_OP)
    ) dut (
        .i_clk     (i_clk),
        .i_rst_n   (i_rst_n),
        .i_rx_data (i_rx_data),
        .i_rx_done (i_rx_done),
        .i_tx_done (i_tx_done),
        .o_tx_data (o_tx_data),
        .o_tx_start(o_tx_start),
        .o_op_err  (o_op_err),
        .o_overrun (o_overrun)
    );

    task automatic check_output(input string name, input logic [31:0] actual,
                                input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
        end
    endtask

    // Reference model: works on integers straight from the operation rules.
    function automatic void model(input int a, input int b, input int op_byte,
                                  output int res, output bit err);
        int op;
        int sa;
        int d;
        op  = op_byte % 64;
        err = 1'b0;
        case (op)
            32: res = (a + b) % 256;
            34: res = (a - b + 256) % 256;
            36: res = a & b;
            37: res = a | b;
            38: res = a ^ b;
            39: res = 255 - (a | b);
            2:  res = (b >= 8) ? 0 : a / (1 << b);
            3: begin
                sa = (a >= 128) ? a - 256 : a;
                if (b >= 8) begin
                    res = (sa < 0) ? 255 : 0;
                end else begin
                    d   = 1 << b;
                    res = (sa >= 0) ? sa / d : -((-sa + d - 1) / d);
                    res = (res + 256) % 256;
                end
            end
            default: begin
                res = 0;
                err = 1'b1;
            end
        endcase
    endfunction

    // One received byte: strobe high for one cycle, then one idle cycle.
    task automatic apply_stimulus(input logic [7:0] data);
        @(negedge i_clk);
        i_rx_data = data;
        i_rx_done = 1'b1;
        @(negedge i_clk);
        i_rx_done = 1'b0;
    endtask

    task automatic pulse_tx_done();
        @(negedge i_clk);
        i_tx_done = 1'b1;
        @(negedge i_clk);
        i_tx_done = 1'b0;
    endtask

    // Called right after the opcode byte; the start pulse is due at the
    // very next sample point. Waiting is bounded.
    task automatic wait_result(input string name, input logic [7:0] exp_data,
                               input logic exp_err);
        bit seen;
        int waited;
        seen   = 1'b0;
        waited = 0;
        for (int i = 1; i <= 8 && !seen; i++) begin
            @(negedge i_clk);
            if (o_tx_start === 1'b1) begin
                seen   = 1'b1;
                waited = i;
            end
        end
        check_output({name, "/start_seen"}, 32'(seen), 32'd1);
        if (seen) begin
            check_output({name, "/latency"}, 32'(waited), 32'd1);
            check_output({name, "/data"}, 32'(o_tx_data), 32'(exp_data));
            check_output({name, "/op_err"}, 32'(o_op_err), 32'(exp_err));
            check_output({name, "/overrun"}, 32'(o_overrun), 32'd0);
            @(negedge i_clk);
            check_output({name, "/start_one_cycle"}, 32'(o_tx_start), 32'd0);
            check_output({name, "/err_one_cycle"}, 32'(o_op_err), 32'd0);
            check_output({name, "/data_hold"}, 32'(o_tx_data), 32'(exp_data));
        end
    endtask

    task automatic run_op(input string name, input logic [7:0] a, input logic [7:0] b,
                          input logic [7:0] op_byte, input logic [7:0] exp_data,
                          input logic exp_err);
        apply_stimulus(a);
        apply_stimulus(b);
        apply_stimulus(op_byte);
        wait_result(name, exp_data, exp_err);
        pulse_tx_done();
    endtask

    task automatic check_all_zero(input string name);
        check_output({name, "/tx_data"}, 32'(o_tx_data), 32'd0);
        check_output({name, "/tx_start"}, 32'(o_tx_start), 32'd0);
        check_output({name, "/op_err"}, 32'(o_op_err), 32'd0);
        check_output({name, "/overrun"}, 32'(o_overrun), 32'd0);
    endtask

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation did not complete in time");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        logic [7:0] valid_ops [8];
        logic [7:0] ra;
        logic [7:0] rb;
        logic [7:0] rop;
        int         res;
        bit         err;

        vecs[0]  = '{8'h05, 8'h03, 8'h20, 8'h08, 1'b0};
        vecs[1]  = '{8'hFF, 8'h02, 8'h20, 8'h01, 1'b0};
        vecs[2]  = '{8'h01, 8'h02, 8'h22, 8'hFF, 1'b0};
        vecs[3]  = '{8'h90, 8'h03, 8'h03, 8'hF2, 1'b0};
        vecs[4]  = '{8'h90, 8'h03, 8'h02, 8'h12, 1'b0};
        vecs[5]  = '{8'h90, 8'h09, 8'h03, 8'hFF, 1'b0};
        vecs[6]  = '{8'h90, 8'h09, 8'h02, 8'h00, 1'b0};
        vecs[7]  = '{8'h0F, 8'hF0, 8'hC4, 8'h00, 1'b1};
        vecs[8]  = '{8'h0F, 8'hF0, 8'hE7, 8'h00, 1'b0};
        vecs[9]  = '{8'hF0, 8'h3C, 8'h24, 8'h30, 1'b0};
        vecs[10] = '{8'h50, 8'h0A, 8'h25, 8'h5A, 1'b0};
        vecs[11] = '{8'hFF, 8'h0F, 8'h26, 8'hF0, 1'b0};
        vecs[12] = '{8'h80, 8'h08, 8'h02, 8'h00, 1'b0};
        vecs[13] = '{8'h80, 8'h07, 8'h03, 8'hFF, 1'b0};
        vecs[14] = '{8'h40, 8'h08, 8'h03, 8'h00, 1'b0};
        vecs[15] = '{8'h80, 8'h80, 8'h60, 8'h00, 1'b0};

        valid_ops[0] = 8'h20; valid_ops[1] = 8'h22;
        valid_ops[2] = 8'h24; valid_ops[3] = 8'h25;
        valid_ops[4] = 8'h26; valid_ops[5] = 8'h27;
        valid_ops[6] = 8'h02; valid_ops[7] = 8'h03;

        // Reset with no clock edge yet, then with the clock running.
        #2;
        check_all_zero("reset_async");
        repeat (2) @(posedge i_clk);
        #1;
        check_all_zero("reset_clocked");
        @(negedge i_clk);
        i_rst_n = 1'b1;

        // Stray transmitter strobe while idle must not disturb anything.
        pulse_tx_done();

        $display("[TB] directed table");
        for (int i = 0; i < NUM_VECS; i++) begin
            run_op($sformatf("vec%0d", i), vecs[i].a, vecs[i].b, vecs[i].op_byte,
                   vecs[i].exp_data, vecs[i].exp_err);
        end

        $display("[TB] overrun in WAIT_TX and coincident tx_done");
        apply_stimulus(8'h33);
        apply_stimulus(8'h11);
        apply_stimulus(8'h20);
        wait_result("ovr_base", 8'h44, 1'b0);
        @(negedge i_clk);
        i_rx_data = 8'h55;
        i_rx_done = 1'b1;
        @(negedge i_clk);
        i_rx_done = 1'b0;
        check_output("ovr_waittx/overrun", 32'(o_overrun), 32'd1);
        check_output("ovr_waittx/data", 32'(o_tx_data), 32'h44);
        check_output("ovr_waittx/start", 32'(o_tx_start), 32'd0);
        @(negedge i_clk);
        check_output("ovr_waittx/overrun_clear", 32'(o_overrun), 32'd0);
        check_output("ovr_waittx/data_hold", 32'(o_tx_data), 32'h44);
        @(negedge i_clk);
        i_rx_data = 8'h77;
        i_rx_done = 1'b1;
        i_tx_done = 1'b1;
        @(negedge i_clk);
        i_rx_done = 1'b0;
        i_tx_done = 1'b0;
        check_output("ovr_coincident/overrun", 32'(o_overrun), 32'd1);
        run_op("after_coincident", 8'h03, 8'h04, 8'h20, 8'h07, 1'b0);

        $display("[TB] overrun in SEND");
        apply_stimulus(8'h0C);
        apply_stimulus(8'h0A);
        @(negedge i_clk);
        i_rx_data = 8'h26;
        i_rx_done = 1'b1;
        @(negedge i_clk);
        i_rx_data = 8'h99;
        @(negedge i_clk);
        i_rx_done = 1'b0;
        check_output("ovr_send/start", 32'(o_tx_start), 32'd1);
        check_output("ovr_send/overrun", 32'(o_overrun), 32'd1);
        check_output("ovr_send/data", 32'(o_tx_data), 32'h06);
        check_output("ovr_send/op_err", 32'(o_op_err), 32'd0);
        pulse_tx_done();
        run_op("after_ovr_send", 8'h09, 8'h01, 8'h22, 8'h08, 1'b0);

        $display("[TB] held rx strobe counts one byte per cycle");
        @(negedge i_clk);
        i_rx_data = 8'h20;
        i_rx_done = 1'b1;
        repeat (3) @(negedge i_clk);
        i_rx_done = 1'b0;
        wait_result("held_strobe", 8'h40, 1'b0);
        pulse_tx_done();

        $display("[TB] reset after operand B");
        apply_stimulus(8'h11);
        apply_stimulus(8'h22);
        @(negedge i_clk);
        i_rst_n = 1'b0;
        #1;
        check_all_zero("rst_after_b");
        @(negedge i_clk);
        i_rst_n = 1'b1;
        run_op("after_rst_b", 8'h02, 8'h02, 8'h24, 8'h02, 1'b0);

        $display("[TB] reset in WAIT_TX");
        apply_stimulus(8'h01);
        apply_stimulus(8'h01);
        apply_stimulus(8'h20);
        wait_result("rst_tx_base", 8'h02, 1'b0);
        @(negedge i_clk);
        i_rst_n = 1'b0;
        #1;
        check_all_zero("rst_waittx");
        @(negedge i_clk);
        i_rst_n = 1'b1;
        run_op("after_rst_tx", 8'h07, 8'h01, 8'h22, 8'h06, 1'b0);

        $display("[TB] randomized requests");
        for (int n = 0; n < NUM_RAND; n++) begin
            ra = 8'($urandom_range(0, 255));
            if ($urandom_range(0, 1) == 1) begin
                rb = 8'($urandom_range(0, 255));
            end else begin
                rb = 8'($urandom_range(0, 10));
            end
            if ($urandom_range(0, 4) == 0) begin
                rop = 8'($urandom_range(0, 255));
            end else begin
                rop = 8'(($urandom_range(0, 3) << 6) | 32'(valid_ops[$urandom_range(0, 7)]));
            end
            model(int'(ra), int'(rb), int'(rop), res, err);
            run_op($sformatf("rand%0d_a%02h_b%02h_op%02h", n, ra, rb, rop),
                   ra, rb, rop, 8'(res), err);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
